corr_window_seq: RTL and testbench
==================================

CORR_WINDOW_SEQ -- requirements
Module: corr_window_seq

Interface
REQ-001 SHALL have parameter H_RES2, 13'd63, last candidate X (inclusive).
REQ-002 SHALL have parameter V_RES2, 13'd47, last candidate Y (inclusive).
REQ-003 SHALL have parameter TPL_W, 8, template width in pixels.
REQ-004 SHALL have parameter TPL_H, 8, template height in pixels.
REQ-005 SHALL have parameter MAX_OUT, 4, maximum outstanding pixel reads (1..15).
REQ-006 SHALL have port iCLK  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port iRST  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port iStart  input  1  one-cycle pulse: frame and template stored, begin scan.
REQ-009 SHALL have ports oBusy / oDone  output  1 each  scan in progress / scan complete (held).
REQ-010 SHALL have ports oRdReq output 1, iRdAck input 1  pixel read request handshake.
REQ-011 SHALL have ports oRdX / oRdY  output  13 each  frame pixel address (X+u, Y+v).
REQ-012 SHALL have port oTplAddr  output  16  template index v*TPL_W+u, paired with oRdX/oRdY.
REQ-013 SHALL have port iPixValid  input  1  read data returned, in request order, latency >= 1.
REQ-014 SHALL have ports oAccClr / oAccEn  output  1 each  MAC accumulator clear / accumulate.
REQ-015 SHALL have port iCorr  input  32  accumulator value, unsigned, registered in MAC.
REQ-016 SHALL have ports oX / oY  output  13 each  current candidate coordinates.
REQ-017 SHALL have ports oBestX / oBestY output 13 each, oBestCorr output 32  running maximum.

Function
REQ-018 SHALL implement states IDLE, CLEAR, FETCH, DRAIN, SETTLE, COMPARE, NEXT, DONE.
REQ-019 SHALL go IDLE->CLEAR on iStart; iStart SHALL be ignored in every other state except DONE.
REQ-020 SHALL in DONE on iStart clear best registers and oDone, zero X/Y, go CLEAR.
REQ-021 SHALL assert oAccClr for exactly the one cycle in CLEAR, then go FETCH.
REQ-022 SHALL in FETCH assert oRdReq whenever outstanding < MAX_OUT; accepted = oRdReq && iRdAck.
REQ-023 SHALL hold oRdX/oRdY/oTplAddr stable while oRdReq high and not accepted.
REQ-024 SHALL on acceptance advance u 0..TPL_W-1, then v 0..TPL_H-1 (raster order).
REQ-025 SHALL go FETCH->DRAIN on acceptance of request TPL_W*TPL_H, deasserting oRdReq.
REQ-026 SHALL keep outstanding = accepted - returned; same-cycle accept and return leave it unchanged.
REQ-027 SHALL drive oAccEn = iPixValid in FETCH and DRAIN only; iPixValid elsewhere SHALL be ignored.
REQ-028 SHALL go DRAIN->SETTLE when returned count reaches TPL_W*TPL_H (including the cycle of last return).
REQ-029 SHALL spend one cycle in SETTLE (MAC register latency), then go COMPARE.
REQ-030 SHALL in COMPARE load best <= (iCorr, X, Y) if first candidate of scan or iCorr > oBestCorr; ties keep earlier raster candidate.
REQ-031 SHALL in NEXT: if X < H_RES2, X+1; else if Y < V_RES2, X=0, Y+1; else go DONE; otherwise go CLEAR.
REQ-032 SHALL compute oRdX/oRdY in 13 bits without wrap; parameters SHALL satisfy H_RES2+TPL_W-1 < 8192 and V_RES2+TPL_H-1 < 8192.
REQ-033 SHALL drive oBusy high in all states except IDLE and DONE; oDone high only in DONE.
REQ-034 SHALL keep oBestX/oBestY/oBestCorr stable outside COMPARE.

Reset
REQ-035 SHALL on iRST (any state, mid-scan included) go IDLE next cycle with X, Y, u, v, counters, best registers at 0.
REQ-036 SHALL hold oRdReq, oAccClr, oAccEn, oBusy, oDone at 0 during and after reset until iStart.
REQ-037 SHALL ignore iPixValid of reads issued before reset.
REQ-038 SHALL give iRST priority over a simultaneous iStart.

Verification
REQ-039 SHALL cover: H_RES2=V_RES2=1, TPL 2x2, iRdAck=1, fixed 2-cycle read latency, iCorr peak 100 at (1,0) -> oDone, oBestX=1, oBestY=0, oBestCorr=100, 16 accepted reads.
REQ-040 SHALL cover: iRdAck low for 5 cycles mid-FETCH -> address outputs frozen, no request lost, outstanding never > MAX_OUT.
REQ-041 SHALL cover: equal iCorr=50 at all candidates -> oBestX=0, oBestY=0, oBestCorr=50.
REQ-042 SHALL cover: all iCorr=0 -> best = (0,0,0) via first-candidate load, oDone asserted.
REQ-043 SHALL cover: iRST in DRAIN with 3 reads outstanding -> IDLE next cycle, late iPixValid gives no oAccEn, new iStart scans correctly.
REQ-044 SHALL cover: iStart while busy ignored; iStart in DONE restarts with cleared best and oDone low next cycle.

Source files
------------

// File: rtl/corr_window_seq_if.sv
// Pixel-read and MAC control bus between the correlation window sequencer
// (master) and the frame/template memory plus multiply-accumulate datapath
// (slave). Read data comes back in request order; iCorr is the MAC's
// registered accumulator.
interface corr_window_seq_if;
  logic        oRdReq;
  logic        iRdAck;
  logic [12:0] oRdX;
  logic [12:0] oRdY;
  logic [15:0] oTplAddr;
  logic        iPixValid;
  logic        oAccClr;
  logic        oAccEn;
  logic [31:0] iCorr;

  modport master (
    output oRdReq, oRdX, oRdY, oTplAddr, oAccClr, oAccEn,
    input  iRdAck, iPixValid, iCorr
  );

  modport slave (
    input  oRdReq, oRdX, oRdY, oTplAddr, oAccClr, oAccEn,
    output iRdAck, iPixValid, iCorr
  );
endinterface

// File: rtl/corr_window_seq.sv
// Correlation window sequencer: slides a TPL_W x TPL_H template over every
// candidate (X,Y) in [0..H_RES2] x [0..V_RES2], raster order. For each
// candidate it clears the external MAC, issues TPL_W*TPL_H pixel reads with
// up to MAX_OUT in flight, waits for all data to return and be accumulated,
// then keeps the first candidate with the strictly largest correlation.
//
// Parameter constraints (not checked in hardware):
//   1 <= MAX_OUT <= 15, TPL_W*TPL_H <= 65536,
//   H_RES2+TPL_W-1 < 8192, V_RES2+TPL_H-1 < 8192 (addresses never wrap).
module corr_window_seq #(
  parameter logic [12:0] H_RES2  = 13'd63,
  parameter logic [12:0] V_RES2  = 13'd47,
  parameter int          TPL_W   = 8,
  parameter int          TPL_H   = 8,
  parameter int          MAX_OUT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  output logic        oBusy,
  output logic        oDone,
  output logic [12:0] oX,
  output logic [12:0] oY,
  output logic [12:0] oBestX,
  output logic [12:0] oBestY,
  output logic [31:0] oBestCorr,
  corr_window_seq_if.master bus
);

  localparam int NPIX = TPL_W * TPL_H;
  localparam int UW   = (TPL_W > 1) ? $clog2(TPL_W) : 1;
  localparam int VW   = (TPL_H > 1) ? $clog2(TPL_H) : 1;
  localparam int CW   = $clog2(NPIX + 1);

  localparam logic [UW-1:0] U_LAST    = UW'(TPL_W - 1);
  localparam logic [15:0]   TPL_LAST  = 16'(NPIX - 1);
  localparam logic [CW-1:0] RET_LAST  = CW'(NPIX - 1);
  localparam logic [3:0]    OUT_LIMIT = 4'(MAX_OUT);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    SETTLE,
    COMPARE,
    NEXT,
    DONE
  } stateT;

  stateT         stateReg;
  logic [12:0]   xReg;
  logic [12:0]   yReg;
  logic [UW-1:0] uReg;
  logic [VW-1:0] vReg;
  // Raster index of the next template pixel; equals v*TPL_W+u and doubles as
  // the count of reads accepted for the current candidate.
  logic [15:0]   tplAddrReg;
  logic [CW-1:0] retCntReg;
  logic [3:0]    outstandingReg;
  logic [3:0]    outstandingNext;
  logic [12:0]   bestXReg;
  logic [12:0]   bestYReg;
  logic [31:0]   bestCorrReg;
  logic          firstReg;
  logic          rdReqReg;
  logic          accClrReg;
  logic          busyReg;
  logic          doneReg;

  logic inScan;
  logic accepted;
  logic returned;
  logic lastAccept;
  logic lastReturn;
  logic reqOk;

  // Handshake bookkeeping: what completes this cycle and the resulting
  // in-flight count, which decides whether a request may be raised next.
  always_comb begin
    inScan          = (stateReg == FETCH) || (stateReg == DRAIN);
    accepted        = bus.oRdReq && bus.iRdAck;
    returned        = bus.iPixValid && inScan;
    outstandingNext = outstandingReg;
    if (accepted && !returned) begin
      outstandingNext = outstandingReg + 4'd1;
    end else if (!accepted && returned) begin
      outstandingNext = outstandingReg - 4'd1;
    end
    lastAccept = accepted && (tplAddrReg == TPL_LAST);
    lastReturn = returned && (retCntReg == RET_LAST);
    reqOk      = (outstandingNext < OUT_LIMIT);
  end

  // Scan FSM with all state, counters and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateReg       <= IDLE;
      xReg           <= '0;
      yReg           <= '0;
      uReg           <= '0;
      vReg           <= '0;
      tplAddrReg     <= '0;
      retCntReg      <= '0;
      outstandingReg <= '0;
      bestXReg       <= '0;
      bestYReg       <= '0;
      bestCorrReg    <= '0;
      firstReg       <= 1'b0;
      rdReqReg       <= 1'b0;
      accClrReg      <= 1'b0;
      busyReg        <= 1'b0;
      doneReg        <= 1'b0;
    end else begin
      accClrReg      <= 1'b0;
      outstandingReg <= outstandingNext;

      if (returned) begin
        retCntReg <= retCntReg + CW'(1);
      end

      // Template walk advances only when the current address is taken.
      if (accepted) begin
        tplAddrReg <= tplAddrReg + 16'd1;
        if (uReg == U_LAST) begin
          uReg <= '0;
          vReg <= vReg + VW'(1);
        end else begin
          uReg <= uReg + UW'(1);
        end
      end

      case (stateReg)
        IDLE: begin
          if (iStart) begin
            xReg      <= '0;
            yReg      <= '0;
            firstReg  <= 1'b1;
            busyReg   <= 1'b1;
            accClrReg <= 1'b1;
            stateReg  <= CLEAR;
          end
        end

        CLEAR: begin
          uReg       <= '0;
          vReg       <= '0;
          tplAddrReg <= '0;
          retCntReg  <= '0;
          rdReqReg   <= reqOk;
          stateReg   <= FETCH;
        end

        FETCH: begin
          if (lastAccept) begin
            rdReqReg <= 1'b0;
            stateReg <= DRAIN;
          end else begin
            rdReqReg <= reqOk;
          end
        end

        DRAIN: begin
          if (lastReturn) begin
            stateReg <= SETTLE;
          end
        end

        // The MAC registers the final sample at the end of the last DRAIN
        // cycle; one more cycle lets that value settle onto iCorr.
        SETTLE: begin
          stateReg <= COMPARE;
        end

        // Strict '>' keeps the earliest raster candidate on ties.
        COMPARE: begin
          if (firstReg || (bus.iCorr > bestCorrReg)) begin
            bestCorrReg <= bus.iCorr;
            bestXReg    <= xReg;
            bestYReg    <= yReg;
          end
          firstReg <= 1'b0;
          stateReg <= NEXT;
        end

        NEXT: begin
          if (xReg < H_RES2) begin
            xReg      <= xReg + 13'd1;
            accClrReg <= 1'b1;
            stateReg  <= CLEAR;
          end else if (yReg < V_RES2) begin
            xReg      <= '0;
            yReg      <= yReg + 13'd1;
            accClrReg <= 1'b1;
            stateReg  <= CLEAR;
          end else begin
            busyReg  <= 1'b0;
            doneReg  <= 1'b1;
            stateReg <= DONE;
          end
        end

        DONE: begin
          if (iStart) begin
            xReg        <= '0;
            yReg        <= '0;
            bestXReg    <= '0;
            bestYReg    <= '0;
            bestCorrReg <= '0;
            firstReg    <= 1'b1;
            doneReg     <= 1'b0;
            busyReg     <= 1'b1;
            accClrReg   <= 1'b1;
            stateReg    <= CLEAR;
          end
        end

        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  // Request and accumulate strobes are gated by reset so that nothing is
  // issued or accumulated in the cycle reset is first applied.
  assign bus.oRdReq   = rdReqReg && !iRST;
  assign bus.oAccEn   = bus.iPixValid && inScan && !iRST;
  assign bus.oAccClr  = accClrReg;
  assign bus.oRdX     = xReg + 13'(uReg);
  assign bus.oRdY     = yReg + 13'(vReg);
  assign bus.oTplAddr = tplAddrReg;

  assign oBusy     = busyReg;
  assign oDone     = doneReg;
  assign oX        = xReg;
  assign oY        = yReg;
  assign oBestX    = bestXReg;
  assign oBestY    = bestYReg;
  assign oBestCorr = bestCorrReg;

endmodule

// File: tb/tb_corr_window_seq.sv
// Bench for corr_window_seq on a 2x2 candidate grid with a 2x2 template.
// The bench plays memory (in-order returns after a chosen latency) and MAC
// (accumulator register). Only template pixel 0 carries data, set to the
// candidate's intended correlation, so iCorr at COMPARE equals that value.
module tb_corr_window_seq;

  localparam int SCAN_READS = 16;
  localparam int TIMEOUT    = 2000;

  typedef struct {
    int              lat;
    int              ackMode;    // 0 always ack, 1 five-cycle stall, 2 random
    int              midStart;   // scan cycle of an extra iStart (0 = none)
    logic [3:0][31:0] corr;      // index y*2+x
    logic [12:0]     expX;
    logic [12:0]     expY;
    logic [31:0]     expCorr;
    int              expMaxOut;  // 0 = only bound by MAX_OUT
  } vecT;

  typedef struct packed {
    logic [12:0] x;
    logic [12:0] y;
    logic [15:0] tpl;
  } addrT;

  typedef struct {
    int          due;
    logic [31:0] pix;
  } retT;

  typedef struct {
    logic [12:0] x;
    logic [12:0] y;
    logic [31:0] corr;
  } bestT;

  logic        iCLK;
  logic        iRST;
  logic        iStart;
  logic        oBusy;
  logic        oDone;
  logic [12:0] oX;
  logic [12:0] oY;
  logic [12:0] oBestX;
  logic [12:0] oBestY;
  logic [31:0] oBestCorr;

  corr_window_seq_if bus ();

  corr_window_seq #(
    .H_RES2 (13'd1),
    .V_RES2 (13'd1),
    .TPL_W  (2),
    .TPL_H  (2),
    .MAX_OUT(4)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iStart   (iStart),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oX       (oX),
    .oY       (oY),
    .oBestX   (oBestX),
    .oBestY   (oBestY),
    .oBestCorr(oBestCorr),
    .bus      (bus)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  vecT  vecs[7];
  addrT addrQ[$];
  retT  retQ[$];
  bestT bestQ[$];

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  int lat = 2;
  int ackMode = 0;
  int stallLeft = 0;
  bit stalled = 0;
  int acceptedInScan = 0;
  int accEnCnt = 0;
  int accClrCnt = 0;
  int curOut = 0;
  int maxOut = 0;
  bit prevStall = 0;
  logic [41:0] prevAddr = '0;
  bit startReq = 0;
  bit rstReq = 0;
  logic [31:0] accModel = '0;
  logic [3:0][31:0] corrTbl = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vecT mkVec(input int l, input int am, input int ms,
                                input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3,
                                input logic [12:0] ex, input logic [12:0] ey,
                                input logic [31:0] ec, input int mo);
    vecT v;
    v.lat = l; v.ackMode = am; v.midStart = ms;
    v.corr[0] = c0; v.corr[1] = c1; v.corr[2] = c2; v.corr[3] = c3;
    v.expX = ex; v.expY = ey; v.expCorr = ec; v.expMaxOut = mo;
    return v;
  endfunction

  // Expected read stream of one full scan: candidates raster, template raster.
  task automatic pushAddrs();
    addrQ.delete();
    for (int cy = 0; cy < 2; cy++)
      for (int cx = 0; cx < 2; cx++)
        for (int tv = 0; tv < 2; tv++)
          for (int tu = 0; tu < 2; tu++)
            addrQ.push_back('{x: 13'(cx + tu), y: 13'(cy + tv), tpl: 16'(tv * 2 + tu)});
  endtask

  // One clock: drive inputs at the falling edge, observe 1 time unit later,
  // then update the memory / MAC model for what the DUT will capture.
  task automatic step();
    logic        acc;
    logic        validNow;
    logic [31:0] pixNow;
    addrT        e;
    logic [31:0] pix;
    int          idx;
    @(negedge iCLK);
    cyc++;
    iRST   = rstReq;
    iStart = startReq;
    case (ackMode)
      1: begin
        if (!stalled && acceptedInScan == 6) begin
          stalled   = 1;
          stallLeft = 5;
        end
        bus.iRdAck = (stallLeft == 0);
        if (stallLeft > 0) stallLeft--;
      end
      2:       bus.iRdAck = 1'($urandom_range(0, 1));
      default: bus.iRdAck = 1'b1;
    endcase
    validNow = 1'b0;
    pixNow   = '0;
    if (retQ.size() > 0 && retQ[0].due == cyc) begin
      validNow = 1'b1;
      pixNow   = retQ[0].pix;
      void'(retQ.pop_front());
    end
    bus.iPixValid = validNow;
    bus.iCorr     = accModel;
    #1;
    if (prevStall) begin
      check("hold_req", bus.oRdReq, 1'b1);
      check("hold_addr", {bus.oRdX, bus.oRdY, bus.oTplAddr}, prevAddr);
    end
    acc = (bus.oRdReq === 1'b1) && (bus.iRdAck === 1'b1);
    if (acc) begin
      acceptedInScan++;
      curOut++;
      if (addrQ.size() == 0) begin
        nCmp++;
        nFail++;
        $display("FAIL read_addr: got unexpected read x=%0d y=%0d t=%0d, expected none",
                 bus.oRdX, bus.oRdY, bus.oTplAddr);
      end else begin
        e = addrQ.pop_front();
        check("read_addr", {bus.oRdX, bus.oRdY, bus.oTplAddr}, e);
        idx = int'(e.y) * 2 + int'(e.x);
        pix = (e.tpl == 16'd0 && idx < 4) ? corrTbl[idx] : 32'd0;
        retQ.push_back('{due: cyc + lat, pix: pix});
      end
    end
    if (validNow) curOut--;
    if (curOut > maxOut) maxOut = curOut;
    if (bus.oAccEn === 1'b1) accEnCnt++;
    if (bus.oAccClr === 1'b1) accClrCnt++;
    if (bus.oAccClr === 1'b1) accModel = '0;
    else if (bus.oAccEn === 1'b1) accModel = accModel + pixNow;
    prevStall = (bus.oRdReq === 1'b1) && (bus.iRdAck !== 1'b1);
    prevAddr  = {bus.oRdX, bus.oRdY, bus.oTplAddr};
  endtask

  task automatic run_scan(input int i);
    vecT  v;
    bestT b;
    int   n;
    v = vecs[i];
    lat = v.lat; ackMode = v.ackMode; corrTbl = v.corr;
    stalled = 0; stallLeft = 0;
    acceptedInScan = 0; accEnCnt = 0; accClrCnt = 0; maxOut = 0;
    pushAddrs();
    bestQ.push_back('{x: v.expX, y: v.expY, corr: v.expCorr});
    startReq = 1;
    step();
    startReq = 0;
    step();
    check("start_busy", oBusy, 1'b1);
    check("start_done_low", oDone, 1'b0);
    check("start_best_clr", {oBestX, oBestY, oBestCorr}, '0);
    check("start_accclr", bus.oAccClr, 1'b1);
    n = 0;
    while (oDone !== 1'b1 && n < TIMEOUT) begin
      if (v.midStart != 0 && n == v.midStart) startReq = 1;
      step();
      startReq = 0;
      n++;
    end
    check("scan_done", oDone, 1'b1);
    b = bestQ.pop_front();
    check("best_x", oBestX, b.x);
    check("best_y", oBestY, b.y);
    check("best_corr", oBestCorr, b.corr);
    check("reads", acceptedInScan, SCAN_READS);
    check("acc_en", accEnCnt, SCAN_READS);
    check("acc_clr", accClrCnt, 4);
    check("addr_left", addrQ.size(), 0);
    check("done_busy", oBusy, 1'b0);
    if (v.expMaxOut > 0) check("max_out", maxOut, v.expMaxOut);
    else check("max_out_bound", (maxOut > 4), 1'b0);
    $display("scan %0d: lat %0d ack %0d -> best (%0d,%0d) corr %0d, %0d reads, max in flight %0d",
             i, v.lat, v.ackMode, oBestX, oBestY, oBestCorr, acceptedInScan, maxOut);
  endtask

  initial begin
    int  lateSeen;
    bit  found;
    int  n;

    //            lat ack mid  c(0,0)        c(1,0) c(0,1) c(1,1) bestX bestY bestCorr     maxOut
    vecs[0] = mkVec(2, 0, 0,  32'd0,        32'd100, 32'd30, 32'd20, 1, 0, 32'd100,        2);
    vecs[1] = mkVec(2, 1, 0,  32'd5,        32'd6,   32'd7,  32'd8,  1, 1, 32'd8,          0);
    vecs[2] = mkVec(1, 0, 0,  32'd50,       32'd50,  32'd50, 32'd50, 0, 0, 32'd50,         1);
    vecs[3] = mkVec(3, 0, 0,  32'd0,        32'd0,   32'd0,  32'd0,  0, 0, 32'd0,          3);
    vecs[4] = mkVec(6, 0, 0,  32'd10,       32'd90,  32'd90, 32'd3,  1, 0, 32'd90,         4);
    vecs[5] = mkVec(4, 2, 25, 32'd200,      32'd7,   32'd300,32'd300,0, 1, 32'd300,        0);
    vecs[6] = mkVec(1, 0, 9,  32'hFFFFFFFF, 32'd1,   32'd2,  32'd3,  0, 0, 32'hFFFFFFFF,   1);

    iRST = 1'b0;
    iStart = 1'b0;
    bus.iRdAck = 1'b0;
    bus.iPixValid = 1'b0;
    bus.iCorr = '0;

    // Reset state, during and after reset.
    rstReq = 1;
    repeat (3) step();
    check("rst_busy", oBusy, 1'b0);
    check("rst_done", oDone, 1'b0);
    check("rst_rdreq", bus.oRdReq, 1'b0);
    check("rst_accclr", bus.oAccClr, 1'b0);
    rstReq = 0;
    repeat (2) step();
    check("idle_busy", oBusy, 1'b0);
    check("idle_done", oDone, 1'b0);
    check("idle_rdreq", bus.oRdReq, 1'b0);
    check("idle_accclr", bus.oAccClr, 1'b0);
    check("idle_xy", {oX, oY}, '0);
    check("idle_best", {oBestX, oBestY, oBestCorr}, '0);

    for (int i = 0; i < 7; i++) run_scan(i);

    // Reset while candidate (1,0) is draining with three reads in flight.
    ackMode = 0; lat = 6; stalled = 0; stallLeft = 0;
    corrTbl = '0;
    corrTbl[0] = 32'd77;
    acceptedInScan = 0; maxOut = 0;
    pushAddrs();
    startReq = 1;
    step();
    startReq = 0;
    found = 0;
    n = 0;
    while (!found && n < 300) begin
      step();
      n++;
      if (curOut == 3 && acceptedInScan == 8 && bus.oRdReq === 1'b0) found = 1;
    end
    check("drain_window_found", found, 1'b1);
    check("pre_rst_x", oX, 13'd1);
    check("pre_rst_best", oBestCorr, 32'd77);
    rstReq = 1;
    lateSeen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      rstReq = 0;
      if (bus.iPixValid === 1'b1) begin
        lateSeen++;
        check("late_acc_en", bus.oAccEn, 1'b0);
      end
      if (k == 1) begin
        check("post_rst_busy", oBusy, 1'b0);
        check("post_rst_done", oDone, 1'b0);
        check("post_rst_rdreq", bus.oRdReq, 1'b0);
        check("post_rst_xy", {oX, oY}, '0);
        check("post_rst_best", {oBestX, oBestY, oBestCorr}, '0);
      end
    end
    check("late_returns", lateSeen, 3);
    addrQ.delete();
    run_scan(0);

    // Reset and start together from DONE: reset wins.
    rstReq = 1;
    startReq = 1;
    step();
    rstReq = 0;
    startReq = 0;
    step();
    check("rst_vs_start_busy", oBusy, 1'b0);
    check("rst_vs_start_done", oDone, 1'b0);
    check("rst_vs_start_accclr", bus.oAccClr, 1'b0);
    check("rst_vs_start_best", oBestCorr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
